// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master AXI-Lite memory arbiter.
// Pure declarations: no latency, no flow control of its own.
package mem_arb_pkg;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_id_e;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_ADDR = 2'd1,
        RD_DATA = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_ADDR = 2'd1,
        WR_RESP = 2'd2
    } wr_state_e;

endpackage

// File: rtl/axil_interface_if.sv
// AXI-Lite bundle split into read and write modports for each side of the link.
// Wires only: no latency; standard valid/ready on every channel.
interface axil_interface_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport rd_slv (input  araddr, arvalid, rready,
                    output arready, rdata, rresp, rvalid);
    modport rd_mst (output araddr, arvalid, rready,
                    input  arready, rdata, rresp, rvalid);
    modport wr_slv (input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
                    output awready, wready, bresp, bvalid);
    modport wr_mst (output awaddr, awvalid, wdata, wstrb, wvalid, bready,
                    input  awready, wready, bresp, bvalid);
endinterface

// File: rtl/axil_arb_pick2.sv
// Two-requester winner select; round-robin pointer when AXIL_ARB_ROUND_ROBIN_EN, else m0 wins ties.
// Combinational select; pointer moves on the grant cycle only, no backpressure.
module axil_arb_pick2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       grant_i,
    output master_id_e winner_o
);

`ifdef AXIL_ARB_ROUND_ROBIN_EN
    // prio_q names the master that wins the next tie
    master_id_e prio_q, prio_d;

    always_comb begin
        if (req0_i && req1_i) winner_o = prio_q;
        else if (req1_i)      winner_o = M1;
        else                  winner_o = M0;
    end

    always_comb begin
        prio_d = prio_q;
        if (grant_i && (req0_i || req1_i))
            prio_d = (winner_o == M0) ? M1 : M0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prio_q <= M0;
        else        prio_q <= prio_d;
    end
`else
    logic unused_pick;
    assign unused_pick = ^{clk, rst_n, grant_i};

    always_comb begin
        if (req0_i)      winner_o = M0;
        else if (req1_i) winner_o = M1;
        else             winner_o = M0;
    end
`endif

endmodule

// File: rtl/axil_mem_arbiter.sv
// Shares one AXI-Lite memory port between m0 (data) and m1 (fetch); read and write arbitrated independently.
// 1-cycle arbitration then combinational passthrough; grant held until response handshake. AXIL_ARB_ROUND_ROBIN_EN selects round-robin.
module axil_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    axil_interface_if.rd_slv  m0_read,
    axil_interface_if.wr_slv  m0_write,
    axil_interface_if.rd_slv  m1_read,
    axil_interface_if.wr_slv  m1_write,
    axil_interface_if.rd_mst  mem_read,
    axil_interface_if.wr_mst  mem_write
);

    rd_state_e  rd_state_q, rd_state_d;
    master_id_e rd_grant_q, rd_grant_d, rd_winner;
    wr_state_e  wr_state_q, wr_state_d;
    master_id_e wr_grant_q, wr_grant_d, wr_winner;
    logic       aw_done_q, aw_done_d, w_done_q, w_done_d;

    logic [ADDR_WIDTH-1:0]   sel_araddr, sel_awaddr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [DATA_WIDTH/8-1:0] sel_wstrb;
    logic sel_arvalid, sel_rready, sel_awvalid, sel_wvalid, sel_bready;
    logic rd_ar_hs, rd_r_hs, wr_aw_hs, wr_w_hs, wr_b_hs;

    axil_arb_pick2 u_rd_pick (
        .clk(clk), .rst_n(rst_n),
        .req0_i(m0_read.arvalid), .req1_i(m1_read.arvalid),
        .grant_i(rd_state_q == RD_IDLE), .winner_o(rd_winner)
    );

    axil_arb_pick2 u_wr_pick (
        .clk(clk), .rst_n(rst_n),
        .req0_i(m0_write.awvalid || m0_write.wvalid),
        .req1_i(m1_write.awvalid || m1_write.wvalid),
        .grant_i(wr_state_q == WR_IDLE), .winner_o(wr_winner)
    );

    always_comb begin
        sel_araddr  = (rd_grant_q == M1) ? m1_read.araddr   : m0_read.araddr;
        sel_arvalid = (rd_grant_q == M1) ? m1_read.arvalid  : m0_read.arvalid;
        sel_rready  = (rd_grant_q == M1) ? m1_read.rready   : m0_read.rready;
        sel_awaddr  = (wr_grant_q == M1) ? m1_write.awaddr  : m0_write.awaddr;
        sel_awvalid = (wr_grant_q == M1) ? m1_write.awvalid : m0_write.awvalid;
        sel_wdata   = (wr_grant_q == M1) ? m1_write.wdata   : m0_write.wdata;
        sel_wstrb   = (wr_grant_q == M1) ? m1_write.wstrb   : m0_write.wstrb;
        sel_wvalid  = (wr_grant_q == M1) ? m1_write.wvalid  : m0_write.wvalid;
        sel_bready  = (wr_grant_q == M1) ? m1_write.bready  : m0_write.bready;
    end

    assign rd_ar_hs = (rd_state_q == RD_ADDR) && sel_arvalid && mem_read.arready;
    assign rd_r_hs  = (rd_state_q == RD_DATA) && mem_read.rvalid && sel_rready;
    assign wr_aw_hs = (wr_state_q == WR_ADDR) && !aw_done_q && sel_awvalid && mem_write.awready;
    assign wr_w_hs  = (wr_state_q == WR_ADDR) && !w_done_q && sel_wvalid && mem_write.wready;
    assign wr_b_hs  = (wr_state_q == WR_RESP) && mem_write.bvalid && sel_bready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= RD_IDLE;
            rd_grant_q <= M0;
            wr_state_q <= WR_IDLE;
            wr_grant_q <= M0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_grant_q <= rd_grant_d;
            wr_state_q <= wr_state_d;
            wr_grant_q <= wr_grant_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_grant_d = rd_grant_q;
        case (rd_state_q)
            RD_IDLE: if (m0_read.arvalid || m1_read.arvalid) begin
                rd_state_d = RD_ADDR;
                rd_grant_d = rd_winner;
            end
            RD_ADDR: if (rd_ar_hs) rd_state_d = RD_DATA;
            RD_DATA: if (rd_r_hs)  rd_state_d = RD_IDLE;
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        mem_read.araddr  = '0;
        mem_read.arvalid = 1'b0;
        mem_read.rready  = 1'b0;
        m0_read.arready  = 1'b0;
        m0_read.rdata    = '0;
        m0_read.rresp    = '0;
        m0_read.rvalid   = 1'b0;
        m1_read.arready  = 1'b0;
        m1_read.rdata    = '0;
        m1_read.rresp    = '0;
        m1_read.rvalid   = 1'b0;
        if (rd_state_q == RD_ADDR) begin
            mem_read.araddr  = sel_araddr;
            mem_read.arvalid = sel_arvalid;
            if (rd_grant_q == M1) m1_read.arready = mem_read.arready;
            else                  m0_read.arready = mem_read.arready;
        end else if (rd_state_q == RD_DATA) begin
            mem_read.rready = sel_rready;
            if (rd_grant_q == M1) begin
                m1_read.rvalid = mem_read.rvalid;
                m1_read.rdata  = mem_read.rdata;
                m1_read.rresp  = mem_read.rresp;
            end else begin
                m0_read.rvalid = mem_read.rvalid;
                m0_read.rdata  = mem_read.rdata;
                m0_read.rresp  = mem_read.rresp;
            end
        end
    end

    // AW and W complete in either order; the sticky flags remember which is done
    always_comb begin
        wr_state_d = wr_state_q;
        wr_grant_d = wr_grant_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        case (wr_state_q)
            WR_IDLE: if (m0_write.awvalid || m0_write.wvalid ||
                         m1_write.awvalid || m1_write.wvalid) begin
                wr_state_d = WR_ADDR;
                wr_grant_d = wr_winner;
            end
            WR_ADDR: begin
                aw_done_d = aw_done_q || wr_aw_hs;
                w_done_d  = w_done_q || wr_w_hs;
                if (aw_done_d && w_done_d) wr_state_d = WR_RESP;
            end
            WR_RESP: if (wr_b_hs) begin
                wr_state_d = WR_IDLE;
                aw_done_d  = 1'b0;
                w_done_d   = 1'b0;
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        mem_write.awaddr  = '0;
        mem_write.awvalid = 1'b0;
        mem_write.wdata   = '0;
        mem_write.wstrb   = '0;
        mem_write.wvalid  = 1'b0;
        mem_write.bready  = 1'b0;
        m0_write.awready  = 1'b0;
        m0_write.wready   = 1'b0;
        m0_write.bresp    = '0;
        m0_write.bvalid   = 1'b0;
        m1_write.awready  = 1'b0;
        m1_write.wready   = 1'b0;
        m1_write.bresp    = '0;
        m1_write.bvalid   = 1'b0;
        if (wr_state_q == WR_ADDR) begin
            mem_write.awaddr  = sel_awaddr;
            mem_write.awvalid = sel_awvalid && !aw_done_q;
            mem_write.wdata   = sel_wdata;
            mem_write.wstrb   = sel_wstrb;
            mem_write.wvalid  = sel_wvalid && !w_done_q;
            if (wr_grant_q == M1) begin
                m1_write.awready = mem_write.awready && !aw_done_q;
                m1_write.wready  = mem_write.wready && !w_done_q;
            end else begin
                m0_write.awready = mem_write.awready && !aw_done_q;
                m0_write.wready  = mem_write.wready && !w_done_q;
            end
        end else if (wr_state_q == WR_RESP) begin
            mem_write.bready = sel_bready;
            if (wr_grant_q == M1) begin
                m1_write.bvalid = mem_write.bvalid;
                m1_write.bresp  = mem_write.bresp;
            end else begin
                m0_write.bvalid = mem_write.bvalid;
                m0_write.bresp  = mem_write.bresp;
            end
        end
    end

endmodule

// File: tb/tb_axil_mem_arbiter.sv
// Directed bench for axil_mem_arbiter: table of read arbitration rounds plus hand-written write, concurrency, backpressure and reset sequences.
module tb_axil_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    axil_interface_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) m0_if ();
    axil_interface_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) m1_if ();
    axil_interface_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) mem_if ();

    axil_mem_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_read(m0_if.rd_slv), .m0_write(m0_if.wr_slv),
        .m1_read(m1_if.rd_slv), .m1_write(m1_if.wr_slv),
        .mem_read(mem_if.rd_mst), .mem_write(mem_if.wr_mst)
    );

    typedef struct {
        logic        req0;
        logic        req1;
        logic [63:0] addr0;
        logic [63:0] addr1;
        logic [63:0] rdata;
        master_id_e  exp_win;
    } rd_vec_t;

    rd_vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_quiet(input string name);
        check({name, " m0 ready/valid"}, {60'd0, m0_if.arready, m0_if.rvalid, m0_if.awready,
              m0_if.wready} | {63'd0, m0_if.bvalid}, 64'd0);
        check({name, " m1 ready/valid"}, {60'd0, m1_if.arready, m1_if.rvalid, m1_if.awready,
              m1_if.wready} | {63'd0, m1_if.bvalid}, 64'd0);
        check({name, " mem valid/ready"}, {59'd0, mem_if.arvalid, mem_if.rready, mem_if.awvalid,
              mem_if.wvalid, mem_if.bready}, 64'd0);
    endtask

    task automatic run_rd(input int idx, input rd_vec_t v);
        logic [63:0] exp_addr;
        exp_addr = (v.exp_win == M1) ? v.addr1 : v.addr0;
        @(negedge clk);
        m0_if.arvalid = v.req0; m0_if.araddr = v.addr0; m0_if.rready = 1'b1;
        m1_if.arvalid = v.req1; m1_if.araddr = v.addr1; m1_if.rready = 1'b1;
        mem_if.arready = 1'b0; mem_if.rvalid = 1'b0;
        #1 check($sformatf("v%0d idle arvalid", idx), {63'd0, mem_if.arvalid}, 64'd0);
        @(negedge clk);
        mem_if.arready = 1'b1;
        #1;
        check($sformatf("v%0d arvalid", idx), {63'd0, mem_if.arvalid}, 64'd1);
        check($sformatf("v%0d araddr", idx), mem_if.araddr, exp_addr);
        check($sformatf("v%0d arready m0/m1", idx), {62'd0, m0_if.arready, m1_if.arready},
              (v.exp_win == M0) ? 64'd2 : 64'd1);
        @(negedge clk);
        if (v.exp_win == M0) m0_if.arvalid = 1'b0; else m1_if.arvalid = 1'b0;
        mem_if.arready = 1'b0; mem_if.rvalid = 1'b1; mem_if.rdata = v.rdata;
        #1;
        check($sformatf("v%0d rvalid m0/m1", idx), {62'd0, m0_if.rvalid, m1_if.rvalid},
              (v.exp_win == M0) ? 64'd2 : 64'd1);
        check($sformatf("v%0d rdata", idx), (v.exp_win == M0) ? m0_if.rdata : m1_if.rdata, v.rdata);
        check($sformatf("v%0d mem rready", idx), {63'd0, mem_if.rready}, 64'd1);
        @(negedge clk);
        mem_if.rvalid = 1'b0;
        m0_if.arvalid = 1'b0; m1_if.arvalid = 1'b0;
        #1 check($sformatf("v%0d back idle", idx), {62'd0, mem_if.arvalid, m0_if.rvalid | m1_if.rvalid}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, elapsed %0t expected < 200000", $time);
        $fatal(1);
    end

    initial begin
        m0_if.araddr = '0; m0_if.arvalid = 0; m0_if.rready = 0;
        m0_if.awaddr = '0; m0_if.awvalid = 0; m0_if.wdata = '0; m0_if.wstrb = '0;
        m0_if.wvalid = 0; m0_if.bready = 0;
        m1_if.araddr = '0; m1_if.arvalid = 0; m1_if.rready = 0;
        m1_if.awaddr = '0; m1_if.awvalid = 0; m1_if.wdata = '0; m1_if.wstrb = '0;
        m1_if.wvalid = 0; m1_if.bready = 0;
        mem_if.arready = 0; mem_if.rdata = '0; mem_if.rresp = '0; mem_if.rvalid = 0;
        mem_if.awready = 0; mem_if.wready = 0; mem_if.bresp = '0; mem_if.bvalid = 0;

        vecs[0] = '{1'b1, 1'b0, 64'h1000, 64'h0,   64'hDEADBEEF, M0};
        vecs[1] = '{1'b0, 1'b1, 64'h0,    64'h200, 64'h1111,     M1};
`ifdef AXIL_ARB_ROUND_ROBIN_EN
        vecs[2] = '{1'b1, 1'b1, 64'h100, 64'h200, 64'hA0, M0};
        vecs[3] = '{1'b1, 1'b1, 64'h100, 64'h200, 64'hA1, M1};
        vecs[4] = '{1'b1, 1'b1, 64'h100, 64'h200, 64'hA2, M0};
        vecs[5] = '{1'b1, 1'b1, 64'h100, 64'h200, 64'hA3, M1};
`else
        vecs[2] = '{1'b1, 1'b1, 64'h100, 64'h200, 64'hA0, M0};
        vecs[3] = '{1'b1, 1'b1, 64'h100, 64'h200, 64'hA1, M0};
        vecs[4] = '{1'b1, 1'b1, 64'h100, 64'h200, 64'hA2, M0};
        vecs[5] = '{1'b1, 1'b1, 64'h100, 64'h200, 64'hA3, M0};
`endif

        // reset with a request pending must keep everything quiet
        m0_if.arvalid = 1'b1; m0_if.wvalid = 1'b1;
        mem_if.arready = 1'b1; mem_if.rvalid = 1'b1; mem_if.bvalid = 1'b1;
        repeat (2) @(negedge clk);
        #1 check_all_quiet("reset");
        @(negedge clk);
        m0_if.arvalid = 1'b0; m0_if.wvalid = 1'b0;
        mem_if.arready = 1'b0; mem_if.rvalid = 1'b0; mem_if.bvalid = 1'b0;
        rst_n = 1'b1;
        #1 check_all_quiet("post-reset");

        for (int i = 0; i < 6; i++) run_rd(i, vecs[i]);

        // m0 write: W leads AW by three cycles
        @(negedge clk);
        m0_if.wvalid = 1'b1; m0_if.wdata = 64'h55; m0_if.wstrb = 8'hFF; m0_if.bready = 1'b1;
        #1 check("wr idle wvalid", {63'd0, mem_if.wvalid}, 64'd0);
        @(negedge clk);
        mem_if.wready = 1'b1;
        #1;
        check("wr w first", {62'd0, mem_if.wvalid, mem_if.awvalid}, 64'd2);
        check("wr wdata", mem_if.wdata, 64'h55);
        check("wr wstrb", {56'd0, mem_if.wstrb}, 64'hFF);
        check("wr m0 wready", {63'd0, m0_if.wready}, 64'd1);
        @(negedge clk);
        m0_if.wvalid = 1'b0; mem_if.wready = 1'b0;
        #1 check("wr w done", {62'd0, mem_if.wvalid, mem_if.awvalid}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        m0_if.awvalid = 1'b1; m0_if.awaddr = 64'h2000; mem_if.awready = 1'b1;
        #1;
        check("wr aw late", {62'd0, mem_if.wvalid, mem_if.awvalid}, 64'd1);
        check("wr awaddr", mem_if.awaddr, 64'h2000);
        check("wr m0 awready", {63'd0, m0_if.awready}, 64'd1);
        @(negedge clk);
        m0_if.awvalid = 1'b0; mem_if.awready = 1'b0; mem_if.bvalid = 1'b1;
        #1;
        check("wr bvalid m0/m1", {62'd0, m0_if.bvalid, m1_if.bvalid}, 64'd2);
        check("wr mem bready", {63'd0, mem_if.bready}, 64'd1);
        @(negedge clk);
        mem_if.bvalid = 1'b1;
        #1 check("wr single b", {62'd0, m0_if.bvalid, mem_if.awvalid}, 64'd0);
        mem_if.bvalid = 1'b0;

        // concurrent m1 read and m0 write
        @(negedge clk);
        m1_if.arvalid = 1'b1; m1_if.araddr = 64'h40; m1_if.rready = 1'b1;
        m0_if.awvalid = 1'b1; m0_if.awaddr = 64'hFFFF_FFFF_FFFF_F000;
        m0_if.wvalid = 1'b1; m0_if.wdata = 64'hA5A5; m0_if.wstrb = 8'h0F;
        mem_if.arready = 1'b1; mem_if.awready = 1'b1; mem_if.wready = 1'b1;
        #1 check("cc idle", {62'd0, mem_if.arvalid, mem_if.awvalid}, 64'd0);
        @(negedge clk);
        #1;
        check("cc ar+aw+w fwd", {61'd0, mem_if.arvalid, mem_if.awvalid, mem_if.wvalid}, 64'd7);
        check("cc araddr", mem_if.araddr, 64'h40);
        check("cc awaddr", mem_if.awaddr, 64'hFFFF_FFFF_FFFF_F000);
        check("cc wstrb", {56'd0, mem_if.wstrb}, 64'h0F);
        check("cc readies", {60'd0, m1_if.arready, m0_if.awready, m0_if.wready, m0_if.arready}, 64'hE);
        @(negedge clk);
        m1_if.arvalid = 1'b0; m0_if.awvalid = 1'b0; m0_if.wvalid = 1'b0;
        mem_if.arready = 1'b0; mem_if.awready = 1'b0; mem_if.wready = 1'b0;
        mem_if.rvalid = 1'b1; mem_if.rdata = 64'hCAFE; mem_if.bvalid = 1'b1;
        #1;
        check("cc rvalid m0/m1", {62'd0, m0_if.rvalid, m1_if.rvalid}, 64'd1);
        check("cc m1 rdata", m1_if.rdata, 64'hCAFE);
        check("cc bvalid m0/m1", {62'd0, m0_if.bvalid, m1_if.bvalid}, 64'd2);
        @(negedge clk);
        mem_if.rvalid = 1'b0; mem_if.bvalid = 1'b0;

        // m0 read held by rready=0 while m1 waits
        @(negedge clk);
        m0_if.arvalid = 1'b1; m0_if.araddr = 64'h300; m0_if.rready = 1'b0;
        mem_if.arready = 1'b1;
        @(negedge clk);
        m1_if.arvalid = 1'b1; m1_if.araddr = 64'h400;
        #1 check("bp arready m0/m1", {62'd0, m0_if.arready, m1_if.arready}, 64'd2);
        @(negedge clk);
        m0_if.arvalid = 1'b0; mem_if.rvalid = 1'b1; mem_if.rdata = 64'h77;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("bp c%0d m0 rvalid", c), {63'd0, m0_if.rvalid}, 64'd1);
            check($sformatf("bp c%0d rdata", c), m0_if.rdata, 64'h77);
            check($sformatf("bp c%0d no new ar", c), {61'd0, mem_if.arvalid, mem_if.rready, m1_if.arready}, 64'd0);
            @(negedge clk);
        end
        m0_if.rready = 1'b1;
        #1 check("bp release rready", {63'd0, mem_if.rready}, 64'd1);
        @(negedge clk);
        mem_if.rvalid = 1'b0;
        #1 check("bp m1 arb cycle", {63'd0, mem_if.arvalid}, 64'd0);
        @(negedge clk);
        #1;
        check("bp m1 fwd", {62'd0, mem_if.arvalid, m1_if.arready}, 64'd3);
        check("bp m1 araddr", mem_if.araddr, 64'h400);
        @(negedge clk);
        m1_if.arvalid = 1'b0; mem_if.arready = 1'b0;
        mem_if.rvalid = 1'b1; mem_if.rdata = 64'h99; m1_if.rready = 1'b0;
        #1 check("rst pre m1 rvalid", {63'd0, m1_if.rvalid}, 64'd1);

        // asynchronous reset in RD_DATA drops the response immediately
        #1 rst_n = 1'b0;
        #1 check_all_quiet("rst mid-txn");
        @(negedge clk);
        mem_if.rvalid = 1'b0; m1_if.rready = 1'b1;
        rst_n = 1'b1;
        #1 check_all_quiet("rst released");
        @(negedge clk);
        m0_if.arvalid = 1'b1; m0_if.araddr = 64'h500; mem_if.arready = 1'b1;
        #1 check("rst arb cycle", {63'd0, mem_if.arvalid}, 64'd0);
        @(negedge clk);
        #1;
        check("rst first fwd", {62'd0, mem_if.arvalid, m0_if.arready}, 64'd3);
        check("rst first araddr", mem_if.araddr, 64'h500);
        @(negedge clk);
        m0_if.arvalid = 1'b0; mem_if.arready = 1'b0;
        mem_if.rvalid = 1'b1; mem_if.rdata = 64'h5A;
        #1 check("rst first rdata", m0_if.rdata, 64'h5A);
        @(negedge clk);
        mem_if.rvalid = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
